// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and sizing helpers for the serial transmitter
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..dw-1.
  function automatic int cnt_width(input int dw);
    return (dw > 2) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/bit_cnt.sv
// rtl/bit_cnt.sv - saturating up-counter with clear, enable and terminal-count flag
module bit_cnt #(
  parameter int             W    = 2,
  parameter logic [W-1:0]   LAST = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  // Holds at LAST instead of wrapping; only a clear restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with frame and end-of-word outputs
module piso_tx
  import piso_pkg::*;
#(
  parameter int DW        = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          ser_o,
  output logic          frame_o,
  output logic          done_o
);

  localparam int CW = cnt_width(DW);

  state_t        state, state_nxt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic          tc, accept, advance, last;

  bit_cnt #(
    .W    (CW),
    .LAST (CW'(DW - 1))
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (advance),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    ready_o   = 1'b0;
    advance   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE:  ready_o = 1'b1;
      SHIFT: begin
        // Ready on the last bit's retiring edge so a held valid_i chains words with no gap.
        ready_o = tc && enb;
        if (enb) begin
          last    = tc;
          advance = !tc;
        end
      end
    endcase
    accept = valid_i && ready_o;
    if (advance) begin
      shreg_nxt = MSB_FIRST ? {shreg[DW-2:0], 1'b0} : {1'b0, shreg[DW-1:1]};
    end
    if (accept) begin
      shreg_nxt = data_i;
      state_nxt = SHIFT;
    end else if (last) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      ser_o   <= 1'b0;
      frame_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      frame_o <= (state_nxt == SHIFT);
      ser_o   <= (state_nxt == SHIFT) && (MSB_FIRST ? shreg_nxt[DW-1] : shreg_nxt[0]);
      done_o  <= last;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - self-checking bench for piso_tx, MSB-first and LSB-first instances
module tb_piso_tx;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enb = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_a, ser_a, frame_a, done_a;
  logic          ready_b, ser_b, frame_b, done_b;

  always #5 clk = ~clk;

  piso_tx #(.DW(DW), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .enb(enb), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_a), .ser_o(ser_a), .frame_o(frame_a), .done_o(done_a)
  );

  piso_tx #(.DW(DW), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .enb(enb), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_b), .ser_o(ser_b), .frame_o(frame_b), .done_o(done_b)
  );

  typedef struct {
    logic [DW-1:0] word;
    logic [DW-1:0] exp_m;  // serial order for MSB-first, leftmost bit sent first
    logic [DW-1:0] exp_l;  // serial order for LSB-first, leftmost bit sent first
    int            per;    // enb asserted once every per cycles
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int k = 0;

  logic          qa[$];
  logic          qb[$];
  logic [DW-1:0] cur_m = '0, cur_l = '0;
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_cnt = 0;

  function automatic bit m_ready();
    return !m_busy || (m_cnt == DW - 1 && enb);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected serial bits go into the queues on each accept.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      qa.delete();
      qb.delete();
    end else begin
      bit acc;
      acc    = valid_i && m_ready();
      m_done = m_busy && enb && (m_cnt == DW - 1);
      if (acc) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        for (int i = DW - 1; i >= 0; i--) begin
          qa.push_back(cur_m[i]);
          qb.push_back(cur_l[i]);
        end
      end else if (m_busy && enb) begin
        if (m_cnt == DW - 1) m_busy = 1'b0;
        else m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_a", ready_a, m_ready());
      chk("ready_b", ready_b, m_ready());
      chk("frame_a", frame_a, m_busy);
      chk("frame_b", frame_b, m_busy);
      chk("done_a", done_a, m_done);
      chk("done_b", done_b, m_done);
      if (done_a) done_cnt++;
      if (!m_busy) begin
        chk("ser_idle_a", ser_a, 1'b0);
        chk("ser_idle_b", ser_b, 1'b0);
      end else if (enb) begin
        if (qa.size() == 0 || qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ser_queue: got bit with no expected entry at %0t", $time);
        end else begin
          chk("ser_a", ser_a, qa.pop_front());
          chk("ser_b", ser_b, qb.pop_front());
        end
      end
    end
  end

  task automatic step(input int per);
    @(posedge clk);
    #1;
    k++;
    enb = (per <= 1) ? 1'b1 : ((k % per) == 0);
  endtask

  task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] em, input logic [DW-1:0] el);
    data_i  = w;
    cur_m   = em;
    cur_l   = el;
    valid_i = 1'b1;
  endtask

  task automatic wait_idle(input int per);
    int n;
    n = 0;
    while ((m_busy || frame_a) && n < 100) begin
      step(per);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: frame_a=%b still busy, required idle within 100 cycles", frame_a);
    end
    step(per);
    step(per);
  endtask

  initial begin
    vecs[0] = '{word: 4'b1011, exp_m: 4'b1011, exp_l: 4'b1101, per: 1};
    vecs[1] = '{word: 4'b1011, exp_m: 4'b1011, exp_l: 4'b1101, per: 3};
    vecs[2] = '{word: 4'b0110, exp_m: 4'b0110, exp_l: 4'b0110, per: 1};
    vecs[3] = '{word: 4'b1000, exp_m: 4'b1000, exp_l: 4'b0001, per: 2};
    vecs[4] = '{word: 4'b0001, exp_m: 4'b0001, exp_l: 4'b1000, per: 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser", ser_a, 1'b0);
    chk("rst_frame", frame_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ready", ready_a, 1'b1);
    rst = 1'b1;
    step(1);

    foreach (vecs[i]) begin
      done_cnt = 0;
      k = 0;
      enb = 1'b1;
      load(vecs[i].word, vecs[i].exp_m, vecs[i].exp_l);
      step(vecs[i].per);
      valid_i = 1'b0;
      data_i  = DW'($urandom);
      wait_idle(vecs[i].per);
      chk_int("done_pulses_vec", done_cnt, 1);
    end

    // Back-to-back with valid_i held across the boundary.
    done_cnt = 0;
    enb = 1'b1;
    load(4'b1011, 4'b1011, 4'b1101);
    step(1);
    load(4'b0110, 4'b0110, 4'b0110);
    repeat (4) step(1);
    valid_i = 1'b0;
    wait_idle(1);
    chk_int("done_pulses_b2b", done_cnt, 2);

    // A word offered mid-transmission must be dropped.
    done_cnt = 0;
    load(4'b1111, 4'b1111, 4'b1111);
    step(1);
    load(4'b0000, 4'b0000, 4'b0000);
    step(1);
    valid_i = 1'b0;
    wait_idle(1);
    chk_int("done_pulses_ignore", done_cnt, 1);

    // Asynchronous reset after two bits, then a fresh word.
    done_cnt = 0;
    load(4'b1011, 4'b1011, 4'b1101);
    step(1);
    valid_i = 1'b0;
    step(1);
    step(1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ser_a", ser_a, 1'b0);
    chk("arst_frame_a", frame_a, 1'b0);
    chk("arst_done_a", done_a, 1'b0);
    chk("arst_ready_a", ready_a, 1'b1);
    chk("arst_frame_b", frame_b, 1'b0);
    chk("arst_ready_b", ready_b, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(4'b0101, 4'b0101, 4'b1010);
    step(1);
    valid_i = 1'b0;
    wait_idle(1);
    chk_int("done_pulses_after_rst", done_cnt, 1);

    chk_int("queue_a_drained", qa.size(), 0);
    chk_int("queue_b_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
